// File: rtl/seg7_pkg.sv
// Shared types and the segment decoder for the 7-segment scan driver.
// Segment vectors are active-low with bit 0 = segment a through bit 6 = segment g.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'b0111111;

  // BCD nibble to active-low segment pattern; non-decimal codes show a dash.
  function automatic seg7_t bcd_to_seg(input logic [3:0] nib);
    seg7_t s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/RATE_HZ clock cycles.
// Ports:
//   clk       in  system clock, rising edge
//   reset     in  asynchronous active-low reset (count returns to 0)
//   tick      out high while the count is DIV-1
//   tick_next out high while the count is DIV-2, i.e. one cycle before tick
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int RATE_HZ = 1_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic tick_next
);

  localparam int DIV = CLK_HZ / RATE_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick      = (cnt_q == CNT_LAST);
  assign tick_next = (cnt_q == CNT_PRE);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Digits/decimal points are captured into a shadow buffer on load and copied
// to the display buffer only when the scan wraps, so a frame never mixes
// old and new values.
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous active-low reset
//   load    in  capture digits/dp this cycle
//   digits  in  BCD nibbles, digits[3:0] = digit 0 (least significant)
//   dp      in  decimal-point request per digit, 1 = on
//   seg     out segments, active-low, seg[0]=a .. seg[6]=g
//   dp_n    out decimal point, active-low
//   an_n    out digit anodes, active-low, an_n[0] = digit 0
//   frame   out one-cycle pulse as the scan returns to digit 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int N_DIGITS = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame
);

  localparam int IW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam int DW = 4 * N_DIGITS;
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_DIG0  = N_DIGITS'(1);

  logic tick, tick_next, wrap;

  logic [IW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       shadow_dig_q, shadow_dig_d;
  logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DW-1:0]       disp_dig_q, disp_dig_d;
  logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;

  seg7_t               seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic                frame_q, frame_d;

  logic [N_DIGITS-1:0] lz_blank;
  logic                zero_above;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .RATE_HZ(SCAN_HZ)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .tick_next(tick_next)
  );

  assign wrap = tick && (idx_q == IDX_LAST);

  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // Shadow takes every load; on a wrap the display takes the shadow's next
  // value, which already holds the incoming digits when load coincides.
  always_comb begin
    shadow_dig_d = load ? digits : shadow_dig_q;
    shadow_dp_d  = load ? dp     : shadow_dp_q;
    disp_dig_d   = wrap ? shadow_dig_d : disp_dig_q;
    disp_dp_d    = wrap ? shadow_dp_d  : disp_dp_q;
  end

  // Leading-zero mask from the display buffer; it only changes on a wrap,
  // so the decision is fixed for the whole frame. Digit 0 is never blanked.
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (disp_dig_d[4*k +: 4] == 4'd0);
      lz_blank[k] = (BLANK_LZ != 0) && zero_above && !disp_dp_d[k];
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        cur_nib   = disp_dig_d[4*k +: 4];
        cur_dp    = disp_dp_d[k];
        cur_blank = lz_blank[k];
      end
    end
  end

  // Output registers are loaded with next-cycle values: blank for the tick
  // cycle (anti-ghost), and the new digit in the cycle after tick.
  always_comb begin
    if (tick_next) begin
      an_n_d = '1;
      seg_d  = SEG_BLANK;
      dp_n_d = 1'b1;
    end else begin
      an_n_d = ~(AN_DIG0 << idx_d);
      seg_d  = cur_blank ? SEG_BLANK : bcd_to_seg(cur_nib);
      dp_n_d = ~cur_dp;
    end
    frame_d = wrap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      disp_dig_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_q      <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_dig_q   <= disp_dig_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_q      <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp_n  = dp_n_q;
  assign an_n  = an_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIV=10, four digits, leading-zero blanking.
// The reference model derives the scan position from the cycle count since
// reset release: digit shown = (n/10)%4, blank cycle when n%10==9, frame
// start when n%40==0.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_HZ  (1000),
    .SCAN_HZ (100),
    .N_DIGITS(4),
    .BLANK_LZ(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .digits(digits),
    .dp    (dp),
    .seg   (seg),
    .dp_n  (dp_n),
    .an_n  (an_n),
    .frame (frame)
  );

  int pass_cnt = 0;
  int total = 0;
  int n = 0;
  logic [15:0] m_sh_dg = '0, m_ds_dg = '0;
  logic [3:0]  m_sh_dp = '0, m_ds_dp = '0;
  logic [6:0]  segt [16];

  typedef struct packed {
    logic [15:0]     dg;
    logic [3:0]      dv;
    logic [3:0][6:0] seg_exp;  // [k] = expected pattern on digit k
    logic [3:0]      dpn_exp;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
  endtask

  // Digits above the most significant nonzero digit are blank unless their dp is lit.
  function automatic logic [6:0] exp_seg(input int k);
    int msd = 0;
    for (int j = 0; j < 4; j++) if (m_ds_dg[4*j +: 4] != 4'd0) msd = j;
    if (k > msd && !m_ds_dp[k]) return 7'h7F;
    return segt[m_ds_dg[4*k +: 4]];
  endfunction

  task automatic check_outputs();
    int k;
    logic [3:0] an_e;
    if (n == 0) begin
      chk("idle_an", 32'(an_n), 32'hF);
      chk("idle_seg", 32'(seg), 32'h7F);
      chk("idle_dpn", 32'(dp_n), 32'd1);
    end else if (n % 10 == 9) begin
      chk("ghost_blank_an", 32'(an_n), 32'hF);
    end else begin
      k = (n / 10) % 4;
      an_e = ~(4'b0001 << k);
      chk("scan_an", 32'(an_n), 32'(an_e));
      chk("scan_seg", 32'(seg), 32'(exp_seg(k)));
      chk("scan_dpn", 32'(dp_n), 32'(!m_ds_dp[k]));
    end
    chk("frame", 32'(frame), 32'(n > 0 && n % 40 == 0));
  endtask

  task automatic run_cycle(input logic ld, input logic [15:0] dg, input logic [3:0] dv);
    load = ld; digits = dg; dp = dv;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (n % 40 == 39) begin
      m_ds_dg = ld ? dg : m_sh_dg;
      m_ds_dp = ld ? dv : m_sh_dp;
    end
    if (ld) begin
      m_sh_dg = dg;
      m_sh_dp = dv;
    end
    n++;
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) run_cycle(1'b0, 16'h0, 4'h0);
  endtask

  task automatic run_until_phase(input int ph);
    for (int i = 0; i < 40 && (n % 40) != ph; i++) idle(1);
    chk("phase_reach", 32'(n % 40), 32'(ph));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;
    m_sh_dg = '0; m_ds_dg = '0; m_sh_dp = '0; m_ds_dp = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld;
    logic [15:0] dg;
    logic [3:0]  dv;
    int          kk;

    segt[0] = 7'b1000000; segt[1] = 7'b1111001; segt[2] = 7'b0100100; segt[3] = 7'b0110000;
    segt[4] = 7'b0011001; segt[5] = 7'b0010010; segt[6] = 7'b0000010; segt[7] = 7'b1111000;
    segt[8] = 7'b0000000; segt[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) segt[i] = 7'b0111111;

    vecs[0] = '{dg: 16'h1234, dv: 4'b0000,
                seg_exp: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, dpn_exp: 4'b1111};
    vecs[1] = '{dg: 16'h0050, dv: 4'b0000,
                seg_exp: {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, dpn_exp: 4'b1111};
    vecs[2] = '{dg: 16'h0050, dv: 4'b0100,
                seg_exp: {7'h7F, 7'b1000000, 7'b0010010, 7'b1000000}, dpn_exp: 4'b1011};
    vecs[3] = '{dg: 16'h00A0, dv: 4'b0000,
                seg_exp: {7'h7F, 7'h7F, 7'b0111111, 7'b1000000}, dpn_exp: 4'b1111};
    vecs[4] = '{dg: 16'h9876, dv: 4'b0000,
                seg_exp: {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}, dpn_exp: 4'b1111};

    repeat (3) @(posedge clk);
    release_reset();
    idle(85);

    // Table vectors: load mid-frame, then check each digit in the next frame.
    for (int v = 0; v < 5; v++) begin
      run_until_phase(20);
      run_cycle(1'b1, vecs[v].dg, vecs[v].dv);
      run_until_phase(0);
      for (int c = 0; c < 40; c++) begin
        if (n % 10 == 5) begin
          kk = (n / 10) % 4;
          chk($sformatf("vec%0d_seg_d%0d", v, kk), 32'(seg), 32'(vecs[v].seg_exp[kk]));
          chk($sformatf("vec%0d_dpn_d%0d", v, kk), 32'(dp_n), 32'(vecs[v].dpn_exp[kk]));
        end
        idle(1);
      end
    end

    // Two loads within one frame: the following frame shows only the later one.
    run_until_phase(15);
    run_cycle(1'b1, 16'h1111, 4'h0);
    run_until_phase(25);
    run_cycle(1'b1, 16'h2222, 4'h0);
    run_until_phase(0);
    for (int c = 0; c < 40; c++) begin
      if (n % 10 == 5) chk("no_mix_seg", 32'(seg), 32'h24);
      idle(1);
    end

    // Load coinciding with wrap goes straight to the display.
    run_until_phase(39);
    chk("wrap_tick_an", 32'(an_n), 32'hF);
    run_cycle(1'b1, 16'h9876, 4'h0);
    chk("wrap_load_d0_seg", 32'(seg), 32'h02);
    chk("wrap_load_d0_an", 32'(an_n), 32'hE);
    chk("wrap_load_frame", 32'(frame), 32'd1);
    idle(40);

    // Randomized loads, often with leading zeros and occasional decimal points.
    for (int c = 0; c < 400; c++) begin
      ld = ($urandom_range(0, 7) == 0);
      dg = 16'($urandom);
      if ($urandom_range(0, 1) == 1) dg = dg >> (4 * $urandom_range(0, 3));
      dv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      run_cycle(ld, dg, dv);
    end

    // Mid-scan reset: outputs blank at once, then scan restarts showing a single 0.
    run_cycle(1'b1, 16'h8888, 4'hF);
    for (int i = 0; i < 40 && !(n % 10 == 3 && (n / 10) % 4 == 1); i++) idle(1);
    idle(40);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_seg", 32'(seg), 32'h7F);
    chk("rst_async_an", 32'(an_n), 32'hF);
    chk("rst_async_dpn", 32'(dp_n), 32'd1);
    chk("rst_async_frame", 32'(frame), 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    idle(90);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
